seg7_scan_driver: RTL

Parametrised multiplexed 7-segment driver. It time-shares one segment bus across NUM_DIGITS common-anode/cathode digits, adding hex decode, per-digit decimal point and leading-zero blanking. It also adds a guard (ghost-suppression) interval and frame-synchronous tear-free value updates. It sits between datapath result registers and the board display pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_scan_driver_hex_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// segment table, FSM state codes and polarity-aware "off" helpers.
package seg7_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_GUARD = 2'd2;

    // Active-high {g,f,e,d,c,b,a}; lowercase b and d so they differ from 8 and 0.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_off(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

    // Sized for the widest supported display; callers keep the low NUM_DIGITS bits.
    function automatic logic [7:0] dig_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_decode.sv
// Combinational hex nibble to active-high segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with guard interval, leading-zero
// blanking and frame-synchronous (tear-free) value updates.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done
);

    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] DIV_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_OFF_V = seg_off(SEG_ACTIVE_LOW);
    localparam logic [7:0]            DIG_OFF_8 = dig_off(DIG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF_V = DIG_OFF_8[NUM_DIGITS-1:0];
    localparam logic                  DP_OFF_V  = SEG_ACTIVE_LOW;

    state_t                    state;
    logic [IW-1:0]             idx;
    logic [CW-1:0]             cnt;

    logic [4*NUM_DIGITS-1:0]   act_value;
    logic [NUM_DIGITS-1:0]     act_dp;
    logic                      act_blank;
    logic [4*NUM_DIGITS-1:0]   sh_value;
    logic [NUM_DIGITS-1:0]     sh_dp;
    logic                      sh_blank;
    logic                      pending;

    logic                      slot_done;
    logic                      advance;
    logic                      frame_end;
    logic [IW-1:0]             next_idx;
    logic [3:0]                cur_nibble;
    logic [6:0]                cur_pattern;
    logic [NUM_DIGITS-1:0]     blank_vec;
    logic [NUM_DIGITS-1:0]     lit_onehot;

    // advance marks the last cycle of a slot (end of guard, or end of lit
    // time when there is no guard); frame_end is that edge on the last digit.
    always_comb begin
        slot_done = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_SCAN: begin
                slot_done = (cnt == DIV_LAST);
                advance   = slot_done && (GUARD_CYCLES == 0);
            end
            ST_GUARD: advance = (cnt == GUARD_LAST);
            default: ;
        endcase
    end

    assign frame_end  = enable && advance && (idx == IDX_LAST);
    assign next_idx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    assign cur_nibble = act_value[{idx, 2'b00} +: 4];
    assign lit_onehot = NUM_DIGITS'(1) << idx;

    seg7_hex_decode u_decode (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // A digit is blanked when it and every more-significant nibble are zero;
    // digit 0 always shows so a zero value still reads "0".
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        blank_vec   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zeros_above  = zeros_above && (act_value[4*i +: 4] == 4'h0);
            blank_vec[i] = act_blank && zeros_above && (i > 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else if (!enable) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_SCAN;
                    idx   <= '0;
                    cnt   <= '0;
                end
                ST_SCAN: begin
                    if (slot_done) begin
                        cnt <= '0;
                        if (GUARD_CYCLES == 0) idx <= next_idx;
                        else                   state <= ST_GUARD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (advance) begin
                        cnt   <= '0;
                        idx   <= next_idx;
                        state <= ST_SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Loads land in the shadow and wait for a frame boundary so a frame never
    // mixes old and new digits; with no frame running, or on the boundary
    // itself, the new value goes straight to the active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= 1'b0;
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                sh_value <= value;
                sh_dp    <= dp_in;
                sh_blank <= blank_lz;
            end
            if (load && (!enable || frame_end)) begin
                act_value <= value;
                act_dp    <= dp_in;
                act_blank <= blank_lz;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end else if (frame_end && pending) begin
                act_value <= sh_value;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                pending   <= 1'b0;
            end
        end
    end

    // Gating on enable lets the pins go dark on the same edge the FSM drops to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_OFF_V;
            dp         <= DP_OFF_V;
            dig_sel    <= DIG_OFF_V;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (enable && (state == ST_SCAN)) begin
                dig_sel <= DIG_ACTIVE_LOW ? ~lit_onehot : lit_onehot;
                seg     <= blank_vec[idx] ? SEG_OFF_V
                                          : (SEG_ACTIVE_LOW ? ~cur_pattern : cur_pattern);
                dp      <= act_dp[idx] ^ SEG_ACTIVE_LOW;
            end else begin
                seg     <= SEG_OFF_V;
                dp      <= DP_OFF_V;
                dig_sel <= DIG_OFF_V;
            end
        end
    end

endmodule
